// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern checker and generator:
// lock-state encoding and counter sizing helper.
package lfsr_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lfsr_state_e;

    // Bits needed to hold the values 0..terminal inclusive.
    function automatic int cnt_w(input int terminal);
        return (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational LFSR feedback parity; shared by the generator and checker.
module lfsr_feedback #(
    parameter int nbits = 8
) (
    input  logic [nbits-1:0] state_i,
    input  logic [nbits-1:0] tap_i,
    output logic             fb_o
);

    assign fb_o = ^(state_i & tap_i);

endmodule

// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-synchronises a local LFSR image to the received
// stream, then free-runs it and counts mismatching bits until lock is lost.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int nbits    = 8,
    parameter int LOCK_CNT = 16,
    parameter int WIN      = 64,
    parameter int LOSS_CNT = 4,
    parameter int CW       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [nbits-1:0] tap_i,
    input  logic             in_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CW-1:0]    err_count_o
);

    localparam int FILL_W  = cnt_w(nbits);
    localparam int MATCH_W = cnt_w(LOCK_CNT);
    localparam int WBIT_W  = cnt_w(WIN);
    localparam int WERR_W  = cnt_w(LOSS_CNT);

    lfsr_state_e        state_q, state_d;
    logic [nbits-1:0]   r_q, r_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WBIT_W-1:0]  wbit_q, wbit_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pred;
    logic               mism;

    lfsr_feedback #(.nbits(nbits)) u_fb (
        .state_i (r_q),
        .tap_i   (tap_i),
        .fb_o    (pred)
    );

    assign mism = (in_i != pred);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        fill_d  = fill_q;
        match_d = match_q;
        wbit_d  = wbit_q;
        werr_d  = werr_q;
        err_d   = 1'b0;
        if (en_i) begin
            case (state_q)
                HUNT: begin
                    r_d = {in_i, r_q[nbits-1:1]};
                    if (fill_q < FILL_W'(nbits)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else if (!mism && (r_q != '0)) begin
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            wbit_d  = '0;
                            werr_d  = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Image free-runs on its own prediction so a single line
                    // error is reported once rather than corrupting the window.
                    r_d   = {pred, r_q[nbits-1:1]};
                    err_d = mism;
                    if (wbit_q == WBIT_W'(WIN - 1)) begin
                        wbit_d = '0;
                        werr_d = '0;
                    end else begin
                        wbit_d = wbit_q + WBIT_W'(1);
                        if (mism) begin
                            werr_d = werr_q + WERR_W'(1);
                        end
                    end
                    if (mism && (werr_q == WERR_W'(LOSS_CNT - 1))) begin
                        state_d = HUNT;
                        fill_d  = '0;
                        match_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (err_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HUNT;
            r_q     <= '0;
            fill_q  <= '0;
            match_q <= '0;
            wbit_q  <= '0;
            werr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            wbit_q  <= wbit_d;
            werr_q  <= werr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked_o    = (state_q == LOCKED);
    assign err_o       = err_q;
    assign err_count_o = cnt_q;

endmodule
